// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - nibble-stream loader and checksum gate for the 8x12 instruction RAM
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_req            one-cycle request to (re)load the program
//   in_valid/in_data    nibble stream in, bit 0 is the MSB
//   in_ready            loader accepts a nibble this cycle (LOAD or CHECK)
//   rd_addr/rd_instr    combinational fetch read port
//   core_run            program loaded and checksum verified
//   load_err            checksum mismatch on the last load
//   busy                loading or checking
module prog_loader #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 12,
    parameter int NIB_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic               in_valid,
    input  logic [0:NIB_W-1]   in_data,
    output logic               in_ready,
    input  logic [0:ADDR_W-1]  rd_addr,
    output logic [0:INSTR_W-1] rd_instr,
    output logic               core_run,
    output logic               load_err,
    output logic               busy
);

    localparam int NPW   = INSTR_W / NIB_W;
    localparam int CNT_W = $clog2(NPW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t             state, state_nx;
    logic [0:INSTR_W-1] mem [DEPTH];
    logic [0:INSTR_W-1] word_sr;
    logic [0:INSTR_W-1] word_nx;
    logic [0:ADDR_W-1]  wr_ptr;
    logic [CNT_W-1:0]   nib_cnt;
    logic [0:NIB_W-1]   chk;
    logic               xfer;
    logic               last_nib;
    logic               last_word;

    assign xfer      = in_valid && in_ready;
    assign last_nib  = (nib_cnt == CNT_W'(NPW - 1));
    assign last_word = (wr_ptr == ADDR_W'(DEPTH - 1));
    // Older nibbles move toward bit 0, so the first nibble ends up in [0:3].
    assign word_nx   = {word_sr[NIB_W:INSTR_W-1], in_data};
    assign rd_instr  = mem[rd_addr];

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            nib_cnt  <= '0;
            chk      <= '0;
            word_sr  <= '0;
            core_run <= 1'b0;
            load_err <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            // Registered status flags track the state being entered.
            core_run <= (state_nx == S_RUN);
            load_err <= (state_nx == S_ERROR);
            busy     <= (state_nx == S_LOAD) || (state_nx == S_CHECK);
            if (state != S_LOAD && state_nx == S_LOAD) begin
                wr_ptr  <= '0;
                nib_cnt <= '0;
                chk     <= '0;
                word_sr <= '0;
            end else if (state == S_LOAD && xfer) begin
                chk     <= chk ^ in_data;
                word_sr <= word_nx;
                if (last_nib) begin
                    nib_cnt     <= '0;
                    mem[wr_ptr] <= word_nx;
                    wr_ptr      <= last_word ? '0 : wr_ptr + ADDR_W'(1);
                end else begin
                    nib_cnt <= nib_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (load_req) state_nx = S_LOAD;
            S_LOAD:  if (xfer && last_nib && last_word) state_nx = S_CHECK;
            S_CHECK: if (xfer) state_nx = (in_data == chk) ? S_RUN : S_ERROR;
            S_RUN:   if (load_req) state_nx = S_LOAD;
            S_ERROR: if (load_req) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // Decoded outputs
    always_comb begin
        in_ready = (state == S_LOAD) || (state == S_CHECK);
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        in_valid;
    logic [0:3]  in_data;
    logic        in_ready;
    logic [0:2]  rd_addr;
    logic [0:11] rd_instr;
    logic        core_run;
    logic        load_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;

    logic [3:0]  prog [25];
    logic [11:0] model_mem [8];
    logic [14:0] exp_q [$];

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_instr (rd_instr),
        .core_run (core_run),
        .load_err (load_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_ready) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_good_prog();
        logic [3:0] g [25] = '{4'h2, 4'h4, 4'h0, 4'h4, 4'h8, 4'h0, 4'h6, 4'hC, 4'h0,
                               4'h9, 4'h0, 4'h0, 4'h1, 4'hF, 4'h9,
                               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                               4'hE};
        for (int i = 0; i < 25; i++) prog[i] = g[i];
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Streams prog[0..n-1]; gaps inserts 1-3 idle cycles between nibbles,
    // req_at pulses load_req alongside that nibble index (-1 for never).
    task automatic run_load(input int n, input bit gaps, input int req_at);
        logic [11:0] w;
        int wr;
        w  = '0;
        wr = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 4'($urandom);
                end
            end
            @(negedge clk);
            chk("in_ready_load", 32'(in_ready), 32'd1);
            if (i == 1) chk("core_run_low_in_load", 32'(core_run), 32'd0);
            in_valid = 1'b1;
            in_data  = prog[i];
            load_req = (i == req_at);
            if (i < 24) begin
                w = {w[7:0], prog[i]};
                if (i % 3 == 2) begin
                    exp_q.push_back({3'(wr), w});
                    model_mem[wr] = w;
                    wr++;
                end
            end
            @(posedge clk);
            #1 load_req = 1'b0;
        end
    endtask

    task automatic check_mem_model(input string tag);
        logic [14:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            rd_addr = e[14:12];
            #1 chk(tag, 32'(rd_instr), 32'(e[11:0]));
        end
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            #1 chk({tag, "_all"}, 32'(rd_instr), 32'(model_mem[a]));
        end
    endtask

    task automatic check_good_contents(input string tag);
        int golden [8] = '{576, 1152, 1728, 2304, 505, 0, 0, 0};
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            #1 chk(tag, 32'(rd_instr), 32'(golden[a]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int a = 0; a < 8; a++) model_mem[a] = '0;
    endtask

    initial begin
        int r0;
        rst = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
        do_reset();

        // Reset state, then in_valid held in IDLE is ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h7;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        chk("idle_ignore_ready", 32'(in_ready), 32'd0);
        chk("idle_ignore_busy",  32'(busy),     32'd0);
        in_valid = 1'b0;
        check_mem_model("rst_mem");

        // Full load with valid held high; load_req mid-load is ignored
        set_good_prog();
        pulse_load();
        r0 = rdy_cnt;
        run_load(25, 1'b0, 10);
        @(negedge clk);
        chk("full_ready_cycles", 32'(rdy_cnt - r0), 32'd25);
        chk("full_core_run", 32'(core_run), 32'd1);
        chk("full_busy",     32'(busy),     32'd0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_load_err", 32'(load_err), 32'd0);
        // in_valid still high in RUN: must be ignored
        repeat (4) @(negedge clk);
        chk("run_ignore_core_run", 32'(core_run), 32'd1);
        chk("run_ignore_ready",    32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check_mem_model("full_mem");
        check_good_contents("full_golden");

        // Bad checksum
        prog[24] = 4'h3;
        pulse_load();
        run_load(25, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bad_load_err", 32'(load_err), 32'd1);
        chk("bad_core_run", 32'(core_run), 32'd0);
        chk("bad_busy",     32'(busy),     32'd0);
        chk("bad_in_ready", 32'(in_ready), 32'd0);
        check_mem_model("bad_mem");
        set_good_prog();
        pulse_load();
        @(negedge clk);
        chk("reload_err_clear", 32'(load_err), 32'd0);
        chk("reload_busy",      32'(busy),     32'd1);

        // Finish that load with random gaps between nibbles
        run_load(25, 1'b1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("gaps_core_run", 32'(core_run), 32'd1);
        chk("gaps_load_err", 32'(load_err), 32'd0);
        check_mem_model("gaps_mem");
        check_good_contents("gaps_golden");

        // Reset after 7 nibbles of a reload
        pulse_load();
        run_load(7, 1'b0, -1);
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_core_run", 32'(core_run), 32'd0);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            #1 chk("midrst_mem_zero", 32'(rd_instr), 32'd0);
        end
        pulse_load();
        run_load(25, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("fresh_core_run", 32'(core_run), 32'd1);
        check_mem_model("fresh_mem");
        check_good_contents("fresh_golden");

        // Reload from RUN with all-0x111 words
        for (int i = 0; i < 24; i++) prog[i] = 4'h1;
        prog[24] = 4'h0;
        pulse_load();
        @(negedge clk);
        chk("reload_run_low", 32'(core_run), 32'd0);
        run_load(25, 1'b0, -1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ones_core_run", 32'(core_run), 32'd1);
        check_mem_model("ones_mem");
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            #1 chk("ones_273", 32'(rd_instr), 32'd273);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
